// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: CTI type encodings and index/tag width helpers.
package fetch_pkg;

  localparam logic [1:0] CTI_RTR  = 2'b00;
  localparam logic [1:0] CTI_CALL = 2'b01;
  localparam logic [1:0] CTI_JUMP = 2'b10;
  localparam logic [1:0] CTI_COND = 2'b11;

  function automatic int slotIdxW(input int fetchWidth);
    return (fetchWidth > 1) ? $clog2(fetchWidth) : 1;
  endfunction

  function automatic int tagW(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int countW(input int fetchWidth);
    return $clog2(fetchWidth) + 1;
  endfunction

endpackage

// File: rtl/fetch2_cti_alloc.sv
// Control-queue tag allocator: circular head/tail/occupancy with commit and
// misprediction recovery; reports when the current bundle does not fit.
module fetch2_cti_alloc
  import fetch_pkg::*;
#(
  parameter int FETCH_WIDTH = 4,
  parameter int CTIQ_DEPTH  = 16,
  localparam int TW   = tagW(CTIQ_DEPTH),
  localparam int CW   = countW(FETCH_WIDTH),
  localparam int OW   = $clog2(CTIQ_DEPTH) + 1,
  localparam int SUMW = OW + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [FETCH_WIDTH-1:0]    allocMask,
  input  logic                      fire,
  input  logic [CW-1:0]             commitCount,
  input  logic                      recoverFlag,
  input  logic [TW-1:0]             recoverTag,
  output logic [FETCH_WIDTH*TW-1:0] ctiTag,
  output logic                      full
);

  logic [TW-1:0] headQ;
  logic [TW-1:0] tailQ;
  logic [OW-1:0] occQ;
  logic [CW-1:0] nAlloc;
  logic [TW-1:0] headNext;
  logic [TW-1:0] recoverOcc;

  // Tags are handed out consecutively from the tail in slot order.
  always_comb begin
    nAlloc = '0;
    ctiTag = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (allocMask[i]) begin
        ctiTag[i*TW +: TW] = tailQ + TW'(nAlloc);
        nAlloc = nAlloc + CW'(1);
      end
    end
  end

  assign full       = (SUMW'(occQ) + SUMW'(nAlloc)) > SUMW'(CTIQ_DEPTH);
  assign headNext   = headQ + TW'(commitCount);
  assign recoverOcc = recoverTag + TW'(1) - headNext;

  // A zero modulo distance on recovery of a non-empty queue means it is completely full.
  always_ff @(posedge clk) begin
    if (reset) begin
      headQ <= '0;
      tailQ <= '0;
      occQ  <= '0;
    end else begin
      headQ <= headNext;
      if (recoverFlag) begin
        tailQ <= recoverTag + TW'(1);
        occQ  <= (recoverOcc == '0 && occQ != '0) ? OW'(CTIQ_DEPTH) : OW'(recoverOcc);
      end else begin
        if (fire) tailQ <= tailQ + TW'(nAlloc);
        occQ <= occQ + (fire ? OW'(nAlloc) : '0) - OW'(commitCount);
      end
    end
  end

endmodule

// File: rtl/fetch2_predecode_scan.sv
// Fetch stage 2: latches a bundle, scans predecode for the first redirecting CTI,
// builds the valid mask, allocates CTI tags and raises early redirects on BTB misses.
// Optional FS2_PERF_CNT_EN adds saturating redirect and full-stall counters.
module fetch2_predecode_scan
  import fetch_pkg::*;
#(
  parameter int FETCH_WIDTH = 4,
  parameter int CTIQ_DEPTH  = 16,
  parameter int PC_W        = 32,
  parameter int INST_W      = 64,
  parameter int PC_STEP     = 8,
  localparam int SW = slotIdxW(FETCH_WIDTH),
  localparam int TW = tagW(CTIQ_DEPTH),
  localparam int CW = countW(FETCH_WIDTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          fs1Ready_i,
  input  logic [PC_W-1:0]               pc_i,
  input  logic [SW-1:0]                 startSlot_i,
  input  logic [FETCH_WIDTH*INST_W-1:0] bundle_i,
  input  logic [FETCH_WIDTH-1:0]        isCtrl_i,
  input  logic [2*FETCH_WIDTH-1:0]      ctrlType_i,
  input  logic [FETCH_WIDTH-1:0]        predDir_i,
  input  logic [FETCH_WIDTH-1:0]        btbHit_i,
  input  logic [FETCH_WIDTH*PC_W-1:0]   predTarget_i,
  input  logic [PC_W-1:0]               rasTop_i,
  input  logic                          stall_i,
  input  logic                          flush_i,
  input  logic                          recoverFlag_i,
  input  logic [TW-1:0]                 recoverTag_i,
  input  logic [CW-1:0]                 commitCount_i,
  output logic [FETCH_WIDTH-1:0]        instValid_o,
  output logic [FETCH_WIDTH*TW-1:0]     ctiTag_o,
  output logic                          redirect_o,
  output logic [PC_W-1:0]               redirectTarget_o,
  output logic                          redirectCall_o,
  output logic                          redirectRtr_o,
  output logic                          fs2Ready_o,
  output logic                          ctiqFull_o
`ifdef FS2_PERF_CNT_EN
 ,output logic [31:0]                   redirectCnt_o,
  output logic [31:0]                   fullStallCnt_o
`endif
);

  logic                        validQ;
  logic [SW-1:0]               startSlotQ;
  logic [FETCH_WIDTH-1:0]      isCtrlQ;
  logic [2*FETCH_WIDTH-1:0]    ctrlTypeQ;
  logic [FETCH_WIDTH-1:0]      predDirQ;
  logic [FETCH_WIDTH-1:0]      btbHitQ;
  logic [FETCH_WIDTH*PC_W-1:0] predTargetQ;
  logic [PC_W-1:0]             rasTopQ;

  logic                   fire;
  logic                   load;
  logic                   full;
  logic                   found;
  logic [SW-1:0]          k;
  logic [1:0]             kType;
  logic [FETCH_WIDTH-1:0] instValid;

  assign fire = validQ & ~stall_i & ~full;
  assign load = fs1Ready_i & (~validQ | fire);

  // Clearing wins over loading so a flushed or recovered bundle never survives.
  always_ff @(posedge clk) begin
    if (reset || flush_i || recoverFlag_i) validQ <= 1'b0;
    else if (load)                         validQ <= 1'b1;
    else if (fire)                         validQ <= 1'b0;

    if (reset) begin
      startSlotQ  <= '0;
      isCtrlQ     <= '0;
      ctrlTypeQ   <= '0;
      predDirQ    <= '0;
      btbHitQ     <= '0;
      predTargetQ <= '0;
      rasTopQ     <= '0;
    end else if (load) begin
      startSlotQ  <= startSlot_i;
      isCtrlQ     <= isCtrl_i;
      ctrlTypeQ   <= ctrlType_i;
      predDirQ    <= predDir_i;
      btbHitQ     <= btbHit_i;
      predTargetQ <= predTarget_i;
      rasTopQ     <= rasTop_i;
    end
  end

  // Scanning from the top down leaves k at the lowest qualifying slot.
  always_comb begin
    found = 1'b0;
    k     = '0;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      if (SW'(i) >= startSlotQ && isCtrlQ[i] &&
          (predDirQ[i] || ctrlTypeQ[2*i +: 2] != CTI_COND)) begin
        found = 1'b1;
        k     = SW'(i);
      end
    end
  end

  always_comb begin
    instValid = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      instValid[i] = validQ && (SW'(i) >= startSlotQ) && (!found || SW'(i) <= k);
    end
  end

  fetch2_cti_alloc #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .CTIQ_DEPTH  (CTIQ_DEPTH)
  ) ctiAlloc (
    .clk         (clk),
    .reset       (reset),
    .allocMask   (instValid & isCtrlQ),
    .fire        (fire),
    .commitCount (commitCount_i),
    .recoverFlag (recoverFlag_i),
    .recoverTag  (recoverTag_i),
    .ctiTag      (ctiTag_o),
    .full        (full)
  );

  assign kType            = ctrlTypeQ[2*k +: 2];
  assign instValid_o      = instValid;
  assign ctiqFull_o       = full;
  assign fs2Ready_o       = fire;
  assign redirect_o       = fire & found & ~btbHitQ[k];
  assign redirectRtr_o    = redirect_o & (kType == CTI_RTR);
  assign redirectCall_o   = redirect_o & (kType == CTI_CALL);
  assign redirectTarget_o = !redirect_o        ? '0 :
                            (kType == CTI_RTR) ? rasTopQ : predTargetQ[k*PC_W +: PC_W];

`ifdef FS2_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      redirectCnt_o  <= '0;
      fullStallCnt_o <= '0;
    end else begin
      if (redirect_o && redirectCnt_o != '1)            redirectCnt_o  <= redirectCnt_o + 32'd1;
      if (validQ && full && fullStallCnt_o != '1)       fullStallCnt_o <= fullStallCnt_o + 32'd1;
    end
  end
`else
  // Performance counters are compiled out in this build.
`endif

endmodule

// File: tb/tb_fetch2_predecode_scan.sv
// Randomised bench for fetch2_predecode_scan with a slot-list reference model
// and directed scenarios pinned by hand-computed expectations.
module tb_fetch2_predecode_scan;

  localparam int FW  = 4;
  localparam int D   = 16;
  localparam int PCW = 32;
  localparam int IW  = 64;
  localparam int SW  = 2;
  localparam int TW  = 4;
  localparam int CW  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              fs1Ready_i;
  logic [PCW-1:0]    pc_i;
  logic [SW-1:0]     startSlot_i;
  logic [FW*IW-1:0]  bundle_i;
  logic [FW-1:0]     isCtrl_i;
  logic [2*FW-1:0]   ctrlType_i;
  logic [FW-1:0]     predDir_i;
  logic [FW-1:0]     btbHit_i;
  logic [FW*PCW-1:0] predTarget_i;
  logic [PCW-1:0]    rasTop_i;
  logic              stall_i;
  logic              flush_i;
  logic              recoverFlag_i;
  logic [TW-1:0]     recoverTag_i;
  logic [CW-1:0]     commitCount_i;
  logic [FW-1:0]     instValid_o;
  logic [FW*TW-1:0]  ctiTag_o;
  logic              redirect_o;
  logic [PCW-1:0]    redirectTarget_o;
  logic              redirectCall_o;
  logic              redirectRtr_o;
  logic              fs2Ready_o;
  logic              ctiqFull_o;
`ifdef FS2_PERF_CNT_EN
  logic [31:0]       redirectCnt_o;
  logic [31:0]       fullStallCnt_o;
`endif

  int checks = 0;
  int errors = 0;

  bit            mValid;
  int            mHead, mTail, mOcc, mStart;
  logic [FW-1:0] mIsCtrl, mPred, mBtb;
  logic [2*FW-1:0] mType;
  logic [FW*PCW-1:0] mTgt;
  logic [PCW-1:0] mRas;

  logic [FW-1:0]    eMask;
  logic [FW*TW-1:0] eTag;
  logic [PCW-1:0]   eTarget;
  bit eRedir, eCall, eRtr, eFire, eFull;
  int eN;

  fetch2_predecode_scan #(
    .FETCH_WIDTH(FW), .CTIQ_DEPTH(D), .PC_W(PCW), .INST_W(IW), .PC_STEP(8)
  ) dut (
    .clk(clk), .reset(reset), .fs1Ready_i(fs1Ready_i), .pc_i(pc_i),
    .startSlot_i(startSlot_i), .bundle_i(bundle_i), .isCtrl_i(isCtrl_i),
    .ctrlType_i(ctrlType_i), .predDir_i(predDir_i), .btbHit_i(btbHit_i),
    .predTarget_i(predTarget_i), .rasTop_i(rasTop_i), .stall_i(stall_i),
    .flush_i(flush_i), .recoverFlag_i(recoverFlag_i), .recoverTag_i(recoverTag_i),
    .commitCount_i(commitCount_i), .instValid_o(instValid_o), .ctiTag_o(ctiTag_o),
    .redirect_o(redirect_o), .redirectTarget_o(redirectTarget_o),
    .redirectCall_o(redirectCall_o), .redirectRtr_o(redirectRtr_o),
    .fs2Ready_o(fs2Ready_o), .ctiqFull_o(ctiqFull_o)
`ifdef FS2_PERF_CNT_EN
   ,.redirectCnt_o(redirectCnt_o), .fullStallCnt_o(fullStallCnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Walk the live slots as a list: stop at the first redirecting CTI, number CTIs from the tail.
  task automatic computeExpected();
    int k;
    int last;
    int n;
    eMask = '0; eTag = '0; eTarget = '0;
    eRedir = 0; eCall = 0; eRtr = 0;
    k = -1;
    n = 0;
    if (mValid) begin
      for (int i = mStart; i < FW; i++)
        if (k < 0 && mIsCtrl[i] && (mPred[i] || mType[2*i +: 2] != 2'b11)) k = i;
      last = (k >= 0) ? k : FW - 1;
      for (int i = mStart; i <= last; i++) begin
        eMask[i] = 1'b1;
        if (mIsCtrl[i]) begin
          eTag[i*TW +: TW] = TW'((mTail + n) % D);
          n++;
        end
      end
    end
    eN    = n;
    eFull = (mOcc + n) > D;
    eFire = mValid && !stall_i && !eFull;
    if (eFire && k >= 0 && !mBtb[k]) begin
      eRedir = 1;
      if (mType[2*k +: 2] == 2'b00) begin
        eRtr = 1;
        eTarget = mRas;
      end else begin
        eCall = (mType[2*k +: 2] == 2'b01);
        eTarget = mTgt[k*PCW +: PCW];
      end
    end
  endtask

  task automatic checkOutput();
    computeExpected();
    cmp("instValid", instValid_o, eMask);
    cmp("ctiTag", ctiTag_o, eTag);
    cmp("redirect", redirect_o, eRedir);
    cmp("redirectTarget", redirectTarget_o, eTarget);
    cmp("redirectCall", redirectCall_o, eCall);
    cmp("redirectRtr", redirectRtr_o, eRtr);
    cmp("fs2Ready", fs2Ready_o, eFire);
    cmp("ctiqFull", ctiqFull_o, eFull);
  endtask

  task automatic updateModel();
    int newHead;
    int r;
    bit load;
    if (reset) begin
      mValid = 0; mHead = 0; mTail = 0; mOcc = 0;
    end else begin
      assert (int'(commitCount_i) <= mOcc) else $error("[TB] commit exceeds occupancy");
      computeExpected();
      load = fs1Ready_i && (!mValid || eFire);
      newHead = (mHead + int'(commitCount_i)) % D;
      if (recoverFlag_i) begin
        mTail = (int'(recoverTag_i) + 1) % D;
        r = ((int'(recoverTag_i) + 1 - newHead) % D + D) % D;
        mOcc = (r == 0 && mOcc != 0) ? D : r;
      end else begin
        if (eFire) mTail = (mTail + eN) % D;
        mOcc = mOcc + (eFire ? eN : 0) - int'(commitCount_i);
      end
      mHead = newHead;
      if (flush_i || recoverFlag_i) mValid = 0;
      else if (load)                mValid = 1;
      else if (eFire)               mValid = 0;
      if (load) begin
        mStart = int'(startSlot_i); mIsCtrl = isCtrl_i; mType = ctrlType_i;
        mPred = predDir_i; mBtb = btbHit_i; mTgt = predTarget_i; mRas = rasTop_i;
      end
    end
  endtask

  task automatic endCycle();
    if (!reset) checkOutput();
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  task automatic stepCycle();
    #1;
    endCycle();
  endtask

  task automatic idle();
    fs1Ready_i = 0; stall_i = 0; flush_i = 0;
    recoverFlag_i = 0; recoverTag_i = '0; commitCount_i = '0;
  endtask

  task automatic applyStimulus(input logic [SW-1:0] start, input logic [FW-1:0] ctrl,
                               input logic [2*FW-1:0] types, input logic [FW-1:0] pred,
                               input logic [FW-1:0] btb, input logic [FW*PCW-1:0] tgt,
                               input logic [PCW-1:0] ras);
    fs1Ready_i = 1; pc_i = 32'h1000; startSlot_i = start; isCtrl_i = ctrl;
    ctrlType_i = types; predDir_i = pred; btbHit_i = btb; predTarget_i = tgt; rasTop_i = ras;
    bundle_i = {8{$urandom}};
  endtask

  task automatic fillBundle(input logic [FW-1:0] ctrl);
    applyStimulus(0, ctrl, 8'hFF, 4'h0, 4'hF, '0, '0);
    stepCycle();
    idle();
    stepCycle();
  endtask

  task automatic drain(input int c);
    idle();
    commitCount_i = CW'(c);
    stepCycle();
    commitCount_i = '0;
  endtask

  initial begin
    logic [FW*PCW-1:0] tgt;
    int maxCommit;
    reset = 1;
    idle();
    applyStimulus(0, 4'hF, 8'h00, 4'hF, 4'h0, '0, '0);
    @(negedge clk);
    stepCycle();
    stepCycle();
    reset = 0;
    idle();
    #1;
    cmp("resetInstValid", instValid_o, 4'h0);
    cmp("resetRedirect", redirect_o, 1'b0);
    cmp("resetFs2Ready", fs2Ready_o, 1'b0);
    cmp("resetFull", ctiqFull_o, 1'b0);
    cmp("resetTag", ctiTag_o, 16'h0);
    endCycle();

    applyStimulus(0, 4'h0, 8'h00, 4'h0, 4'h0, '0, '0);
    stepCycle();
    idle(); #1;
    cmp("noCtiValid", instValid_o, 4'hF);
    cmp("noCtiRedirect", redirect_o, 1'b0);
    endCycle();

    tgt = '0;
    tgt[1*PCW +: PCW] = 32'h2000;
    applyStimulus(0, 4'b0010, 8'h0C, 4'b0010, 4'h0, tgt, '0);
    stepCycle();
    idle(); #1;
    cmp("takenCondValid", instValid_o, 4'b0011);
    cmp("takenCondRedirect", redirect_o, 1'b1);
    cmp("takenCondTarget", redirectTarget_o, 32'h2000);
    cmp("takenCondTag", ctiTag_o, 16'h0000);
    endCycle();

    applyStimulus(1, 4'b0100, 8'h00, 4'h0, 4'h0, '0, 32'h3ABC);
    stepCycle();
    idle(); #1;
    cmp("returnValid", instValid_o, 4'b0110);
    cmp("returnRtr", redirectRtr_o, 1'b1);
    cmp("returnTarget", redirectTarget_o, 32'h3ABC);
    cmp("returnTag", ctiTag_o, 16'h0100);
    endCycle();
    drain(2);

    fillBundle(4'hF); fillBundle(4'hF); fillBundle(4'hF); fillBundle(4'b0111);
    applyStimulus(0, 4'b0011, 8'hFF, 4'h0, 4'hF, '0, '0);
    stepCycle();
    idle(); #1;
    cmp("fullFlag", ctiqFull_o, 1'b1);
    cmp("fullReady", fs2Ready_o, 1'b0);
    endCycle();
    commitCount_i = 3'd1; #1;
    cmp("fullHeldValid", instValid_o, 4'hF);
    cmp("fullHeldFlag", ctiqFull_o, 1'b1);
    endCycle();
    idle(); #1;
    cmp("fullReleaseReady", fs2Ready_o, 1'b1);
    cmp("fullReleaseTag", ctiTag_o, 16'h0021);
    endCycle();
    applyStimulus(0, 4'b0001, 8'hFF, 4'h0, 4'hF, '0, '0);
    stepCycle();
    idle(); #1;
    cmp("occ16Full", ctiqFull_o, 1'b1);
    endCycle();
    drain(4);
    idle(); stepCycle();
    drain(4); drain(4); drain(4); drain(1);

    fillBundle(4'hF); fillBundle(4'hF); fillBundle(4'b0011);
    drain(4); drain(4); drain(2);
    applyStimulus(0, 4'b0111, 8'hFF, 4'h0, 4'hF, '0, '0);
    stepCycle();
    applyStimulus(0, 4'h0, 8'h00, 4'h0, 4'h0, '0, '0); #1;
    cmp("wrapTags", ctiTag_o, 16'h00FE);
    endCycle();
    idle();
    stall_i = 1; recoverFlag_i = 1; recoverTag_i = 4'd15;
    stepCycle();
    idle(); #1;
    cmp("recoverValid", instValid_o, 4'h0);
    endCycle();

    applyStimulus(0, 4'b0011, 8'hFF, 4'h0, 4'hF, '0, '0);
    flush_i = 1;
    stepCycle();
    idle(); #1;
    cmp("flushValid", instValid_o, 4'h0);
    cmp("flushReady", fs2Ready_o, 1'b0);
    endCycle();
    applyStimulus(0, 4'b0011, 8'hFF, 4'h0, 4'hF, '0, '0);
    stepCycle();
    idle(); #1;
    cmp("postRecoverTags", ctiTag_o, 16'h0010);
    endCycle();
    drain(4);

    for (int c = 0; c < 3000; c++) begin
      fs1Ready_i   = ($urandom_range(0, 3) != 0);
      pc_i         = $urandom;
      bundle_i     = {8{$urandom}};
      startSlot_i  = SW'($urandom_range(0, FW - 1));
      isCtrl_i     = FW'($urandom);
      ctrlType_i   = 8'($urandom);
      predDir_i    = FW'($urandom);
      btbHit_i     = FW'($urandom);
      predTarget_i = {$urandom, $urandom, $urandom, $urandom};
      rasTop_i     = $urandom;
      stall_i      = ($urandom_range(0, 3) == 0);
      flush_i      = ($urandom_range(0, 15) == 0);
      recoverFlag_i = 0;
      recoverTag_i  = '0;
      maxCommit = (mOcc < FW) ? mOcc : FW;
      commitCount_i = ($urandom_range(0, 1) == 0) ? CW'($urandom_range(0, maxCommit)) : '0;
      if (mOcc > 0 && $urandom_range(0, 19) == 0) begin
        recoverFlag_i = 1;
        commitCount_i = '0;
        recoverTag_i  = TW'((mHead + int'($urandom_range(0, mOcc - 1))) % D);
      end
      reset = ($urandom_range(0, 299) == 0);
      stepCycle();
    end
    reset = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
